// File: rtl/store_pkg.sv
// Shared store-unit types: store size encoding and strobe-width helper.
package store_pkg;

    typedef enum logic [1:0] {
        ST_B = 2'b00,
        ST_H = 2'b01,
        ST_W = 2'b10,
        ST_D = 2'b11
    } st_type_e;

    function automatic int strbWidth(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/store_queue_lane_gen.sv
// Combinational store decode: misalignment flag, byte strobes and lane-replicated data.
module st_lane_gen
    import store_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  valid,
    input  logic [1:0]            stType,
    input  logic [2:0]            addrLo,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  ades,
    output logic [DATA_W/8-1:0]   strb,
    output logic [DATA_W-1:0]     data
);

    localparam int STRB_W = strbWidth(DATA_W);
    localparam int OFF    = $clog2(STRB_W);

    logic [OFF-1:0] lane;
    logic           misaligned;

    assign lane = addrLo[OFF-1:0];

    always_comb begin
        misaligned = 1'b0;
        strb       = '0;
        data       = '0;
        case (st_type_e'(stType))
            ST_B: begin
                strb = STRB_W'(1) << lane;
                data = {(DATA_W/8){wdata[7:0]}};
            end
            ST_H: begin
                misaligned = addrLo[0];
                strb       = STRB_W'(2'b11) << lane;
                data       = {(DATA_W/16){wdata[15:0]}};
            end
            ST_W: begin
                misaligned = (addrLo[1:0] != 2'b00);
                strb       = STRB_W'(4'hF) << lane;
                data       = {(DATA_W/32){wdata[31:0]}};
            end
            ST_D: begin
                // A 32-bit bus cannot carry a doubleword in one beat.
                misaligned = (DATA_W == 32) || (addrLo != 3'b000);
                strb       = '1;
                data       = wdata;
            end
            default: ;
        endcase
    end

    assign ades = valid && misaligned;

endmodule

// File: rtl/store_queue.sv
// In-order store buffer between M stage and data memory port.
// Optional tail merging of same-word stores: define STORE_MERGE_EN.
module store_queue
    import store_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  st_validM,
    input  logic [1:0]            st_typeM,
    input  logic [ADDR_W-1:0]     addressM,
    input  logic [DATA_W-1:0]     wdataM,
    output logic                  st_readyM,
    output logic                  adesM,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    output logic                  sq_empty
);

    localparam int STRB_W = strbWidth(DATA_W);
    localparam int OFF    = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    logic [STRB_W-1:0] laneStrb;
    logic [DATA_W-1:0] laneData;
    logic              laneAdes;
    logic [ADDR_W-1:0] alignedAddr;

    logic [ADDR_W-1:0] addrQ [DEPTH];
    logic [STRB_W-1:0] strbQ [DEPTH];
    logic [DATA_W-1:0] dataQ [DEPTH];

    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  count;

    logic full;
    logic empty;
    logic legal;
    logic mergeHit;
    logic push;
    logic pop;

    st_lane_gen #(
        .DATA_W(DATA_W)
    ) u_laneGen (
        .valid  (st_validM),
        .stType (st_typeM),
        .addrLo (addressM[2:0]),
        .wdata  (wdataM),
        .ades   (laneAdes),
        .strb   (laneStrb),
        .data   (laneData)
    );

    assign alignedAddr = {addressM[ADDR_W-1:OFF], {OFF{1'b0}}};

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign st_readyM = !full;
    assign sq_empty  = empty;
    assign mem_req   = !empty;
    assign adesM     = laneAdes;

    assign mem_addr  = addrQ[rdPtr];
    assign mem_wstrb = strbQ[rdPtr];
    assign mem_wdata = dataQ[rdPtr];

    assign legal = st_validM && !laneAdes;

`ifdef STORE_MERGE_EN
    logic [PTR_W-1:0]  tailPtr;
    logic [DATA_W-1:0] mergedData;

    assign tailPtr = wrPtr - PTR_W'(1);
    // count>=2 keeps the tail distinct from the head being presented to memory.
    assign mergeHit = legal && (count >= CNT_W'(2)) && (addrQ[tailPtr] == alignedAddr);

    always_comb begin
        mergedData = dataQ[tailPtr];
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (laneStrb[b]) begin
                mergedData[b*8 +: 8] = laneData[b*8 +: 8];
            end
        end
    end
`else
    assign mergeHit = 1'b0;
`endif

    assign push = legal && st_readyM && !mergeHit;
    assign pop  = mem_req && mem_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addrQ[i] <= '0;
                strbQ[i] <= '0;
                dataQ[i] <= '0;
            end
        end else begin
            if (push) begin
                addrQ[wrPtr] <= alignedAddr;
                strbQ[wrPtr] <= laneStrb;
                dataQ[wrPtr] <= laneData;
                wrPtr        <= wrPtr + PTR_W'(1);
            end
`ifdef STORE_MERGE_EN
            if (mergeHit) begin
                strbQ[tailPtr] <= strbQ[tailPtr] | laneStrb;
                dataQ[tailPtr] <= mergedData;
            end
`endif
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_store_queue.sv
// Directed self-checking bench for store_queue (DATA_W=32, DEPTH=4).
module tb_store_queue;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              st_validM = 1'b0;
    logic [1:0]        st_typeM = 2'b00;
    logic [ADDR_W-1:0] addressM = '0;
    logic [DATA_W-1:0] wdataM = '0;
    logic              st_readyM;
    logic              adesM;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready = 1'b0;
    logic              sq_empty;

    int nCompared   = 0;
    int nMismatched = 0;

    store_queue #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .st_validM (st_validM),
        .st_typeM  (st_typeM),
        .addressM  (addressM),
        .wdataM    (wdataM),
        .st_readyM (st_readyM),
        .adesM     (adesM),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .sq_empty  (sq_empty)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic setStore(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
        st_validM = v;
        st_typeM  = t;
        addressM  = a;
        wdataM    = d;
    endtask

    task automatic test_reset();
        #3;
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
        nCompared++; if (sq_empty !== 1'b1) begin nMismatched++; $display("FAIL reset_sq_empty got %b exp 1", sq_empty); end
        nCompared++; if (st_readyM !== 1'b1) begin nMismatched++; $display("FAIL reset_st_readyM got %b exp 1", st_readyM); end
        nCompared++; if (mem_addr !== 32'h0) begin nMismatched++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        nCompared++; if (mem_wstrb !== 4'h0) begin nMismatched++; $display("FAIL reset_mem_wstrb got %h exp 0", mem_wstrb); end
        nCompared++; if (mem_wdata !== 32'h0) begin nMismatched++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        @(negedge clk);
        resetn = 1'b1;
        cycle();
    endtask

    task automatic test_byte();
        mem_ready = 1'b1;
        setStore(1'b1, 2'b00, 32'h1003, 32'h0000_00AB);
        cycle();
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        nCompared++; if (mem_req !== 1'b1) begin nMismatched++; $display("FAIL sb_mem_req got %b exp 1", mem_req); end
        nCompared++; if (mem_addr !== 32'h1000) begin nMismatched++; $display("FAIL sb_mem_addr got %h exp 00001000", mem_addr); end
        nCompared++; if (mem_wstrb !== 4'b1000) begin nMismatched++; $display("FAIL sb_mem_wstrb got %b exp 1000", mem_wstrb); end
        nCompared++; if (mem_wdata !== 32'hABAB_ABAB) begin nMismatched++; $display("FAIL sb_mem_wdata got %h exp ababab", mem_wdata); end
        nCompared++; if (sq_empty !== 1'b0) begin nMismatched++; $display("FAIL sb_sq_empty_busy got %b exp 0", sq_empty); end
        cycle();
        nCompared++; if (sq_empty !== 1'b1) begin nMismatched++; $display("FAIL sb_sq_empty_after_pop got %b exp 1", sq_empty); end
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL sb_mem_req_after_pop got %b exp 0", mem_req); end
    endtask

    task automatic test_half_and_ades();
        mem_ready = 1'b1;
        setStore(1'b1, 2'b01, 32'h2001, 32'h0000_1234);
        #1;
        nCompared++; if (adesM !== 1'b1) begin nMismatched++; $display("FAIL sh_odd_ades got %b exp 1", adesM); end
        cycle();
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL sh_odd_no_enq got %b exp 0", mem_req); end
        setStore(1'b1, 2'b11, 32'h0000, 32'h0);
        #1;
        nCompared++; if (adesM !== 1'b1) begin nMismatched++; $display("FAIL sd_on_32_ades got %b exp 1", adesM); end
        setStore(1'b1, 2'b10, 32'h2002, 32'h0);
        #1;
        nCompared++; if (adesM !== 1'b1) begin nMismatched++; $display("FAIL sw_mis_ades got %b exp 1", adesM); end
        setStore(1'b0, 2'b01, 32'h2001, 32'h0);
        #1;
        nCompared++; if (adesM !== 1'b0) begin nMismatched++; $display("FAIL ades_no_valid got %b exp 0", adesM); end
        setStore(1'b1, 2'b01, 32'h2002, 32'h0000_1234);
        #1;
        nCompared++; if (adesM !== 1'b0) begin nMismatched++; $display("FAIL sh_even_ades got %b exp 0", adesM); end
        cycle();
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        nCompared++; if (mem_addr !== 32'h2000) begin nMismatched++; $display("FAIL sh_mem_addr got %h exp 00002000", mem_addr); end
        nCompared++; if (mem_wstrb !== 4'b1100) begin nMismatched++; $display("FAIL sh_mem_wstrb got %b exp 1100", mem_wstrb); end
        nCompared++; if (mem_wdata !== 32'h1234_1234) begin nMismatched++; $display("FAIL sh_mem_wdata got %h exp 12341234", mem_wdata); end
        cycle();
        nCompared++; if (sq_empty !== 1'b1) begin nMismatched++; $display("FAIL sh_drained got %b exp 1", sq_empty); end
    endtask

    task automatic test_fill_drain();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setStore(1'b1, 2'b10, 32'h4000 + 32'(4*i), 32'(i + 1));
            nCompared++; if (st_readyM !== 1'b1) begin nMismatched++; $display("FAIL fill_ready_%0d got %b exp 1", i, st_readyM); end
            cycle();
        end
        setStore(1'b1, 2'b10, 32'h4010, 32'd5);
        nCompared++; if (st_readyM !== 1'b0) begin nMismatched++; $display("FAIL fill_full_ready got %b exp 0", st_readyM); end
        cycle();
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        nCompared++; if (st_readyM !== 1'b0) begin nMismatched++; $display("FAIL fill_held_off got %b exp 0", st_readyM); end
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            nCompared++; if (mem_addr !== 32'h4000 + 32'(4*k)) begin nMismatched++; $display("FAIL drain_addr_%0d got %h exp %h", k, mem_addr, 32'h4000 + 32'(4*k)); end
            nCompared++; if (mem_wdata !== 32'(k + 1)) begin nMismatched++; $display("FAIL drain_data_%0d got %h exp %h", k, mem_wdata, 32'(k + 1)); end
            cycle();
        end
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL drain_done got %b exp 0", mem_req); end
    endtask

    task automatic test_full_pop();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setStore(1'b1, 2'b10, 32'h5000 + 32'(4*i), 32'h10 + 32'(i));
            cycle();
        end
        setStore(1'b1, 2'b10, 32'h5010, 32'h99);
        mem_ready = 1'b1;
        nCompared++; if (st_readyM !== 1'b0) begin nMismatched++; $display("FAIL fullpop_ready_before got %b exp 0", st_readyM); end
        cycle();
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        nCompared++; if (st_readyM !== 1'b1) begin nMismatched++; $display("FAIL fullpop_ready_after got %b exp 1", st_readyM); end
        for (int k = 1; k < 4; k++) begin
            nCompared++; if (mem_addr !== 32'h5000 + 32'(4*k)) begin nMismatched++; $display("FAIL fullpop_addr_%0d got %h exp %h", k, mem_addr, 32'h5000 + 32'(4*k)); end
            nCompared++; if (mem_wdata !== 32'h10 + 32'(k)) begin nMismatched++; $display("FAIL fullpop_data_%0d got %h exp %h", k, mem_wdata, 32'h10 + 32'(k)); end
            cycle();
        end
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL fullpop_no_fifth got %b exp 0", mem_req); end
    endtask

    task automatic test_back_to_back();
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            setStore(1'b1, 2'b10, 32'h6000 + 32'(4*i), 32'h60 + 32'(i));
            cycle();
            nCompared++; if (mem_addr !== 32'h6000 + 32'(4*i)) begin nMismatched++; $display("FAIL b2b_addr_%0d got %h exp %h", i, mem_addr, 32'h6000 + 32'(4*i)); end
            nCompared++; if (mem_wdata !== 32'h60 + 32'(i)) begin nMismatched++; $display("FAIL b2b_data_%0d got %h exp %h", i, mem_wdata, 32'h60 + 32'(i)); end
        end
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        cycle();
        nCompared++; if (sq_empty !== 1'b1) begin nMismatched++; $display("FAIL b2b_empty got %b exp 1", sq_empty); end
    endtask

    task automatic test_merge();
        mem_ready = 1'b0;
        setStore(1'b1, 2'b10, 32'h3000, 32'hDEAD_BEEF);
        cycle();
        setStore(1'b1, 2'b00, 32'h3010, 32'h11);
        cycle();
        setStore(1'b1, 2'b00, 32'h3011, 32'h22);
        cycle();
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        nCompared++; if (mem_wdata !== 32'hDEAD_BEEF) begin nMismatched++; $display("FAIL merge_head_data got %h exp deadbeef", mem_wdata); end
        mem_ready = 1'b1;
        cycle();
        nCompared++; if (mem_addr !== 32'h3010) begin nMismatched++; $display("FAIL merge_second_addr got %h exp 00003010", mem_addr); end
`ifdef STORE_MERGE_EN
        nCompared++; if (mem_wstrb !== 4'b0011) begin nMismatched++; $display("FAIL merge_wstrb got %b exp 0011", mem_wstrb); end
        nCompared++; if (mem_wdata[15:0] !== 16'h2211) begin nMismatched++; $display("FAIL merge_wdata got %h exp 2211", mem_wdata[15:0]); end
        cycle();
`else
        nCompared++; if (mem_wstrb !== 4'b0001) begin nMismatched++; $display("FAIL nomerge_wstrb2 got %b exp 0001", mem_wstrb); end
        nCompared++; if (mem_wdata !== 32'h1111_1111) begin nMismatched++; $display("FAIL nomerge_wdata2 got %h exp 11111111", mem_wdata); end
        cycle();
        nCompared++; if (mem_wstrb !== 4'b0010) begin nMismatched++; $display("FAIL nomerge_wstrb3 got %b exp 0010", mem_wstrb); end
        nCompared++; if (mem_wdata !== 32'h2222_2222) begin nMismatched++; $display("FAIL nomerge_wdata3 got %h exp 22222222", mem_wdata); end
        cycle();
`endif
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL merge_drained got %b exp 0", mem_req); end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            setStore(1'b1, 2'b10, 32'h7000 + 32'(4*i), 32'h70 + 32'(i));
            cycle();
        end
        setStore(1'b0, 2'b00, 32'h0, 32'h0);
        mem_ready = 1'b1;
        nCompared++; if (mem_req !== 1'b1) begin nMismatched++; $display("FAIL rstmid_pre_req got %b exp 1", mem_req); end
        #2;
        resetn = 1'b0;
        #1;
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL rstmid_async_req got %b exp 0", mem_req); end
        nCompared++; if (sq_empty !== 1'b1) begin nMismatched++; $display("FAIL rstmid_async_empty got %b exp 1", sq_empty); end
        nCompared++; if (mem_addr !== 32'h0) begin nMismatched++; $display("FAIL rstmid_addr got %h exp 0", mem_addr); end
        #3;
        resetn = 1'b1;
        cycle();
        cycle();
        nCompared++; if (mem_req !== 1'b0) begin nMismatched++; $display("FAIL rstmid_after_req got %b exp 0", mem_req); end
        nCompared++; if (st_readyM !== 1'b1) begin nMismatched++; $display("FAIL rstmid_after_ready got %b exp 1", st_readyM); end
    endtask

    initial begin
        test_reset();
        test_byte();
        test_half_and_ades();
        test_fill_drain();
        test_full_pop();
        test_back_to_back();
        test_merge();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
